// File: rtl/alu_types.sv
// Shared ALU operation encodings used by the ALU and by every block that drives it.
package alu_types;

  localparam int ALU_OP_W = 4;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

endpackage

// File: rtl/rv32i_ctrl_pkg.sv
// Control-FSM state codes, RV32I opcodes and datapath mux encodings
// shared by the multicycle controller and its ALU decoder.
package rv32i_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_EXECUTE_R = 4'd3,
    S_EXECUTE_I = 4'd4,
    S_JAL       = 4'd5,
    S_JALR      = 4'd6,
    S_BRANCH    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_MEM_READ  = 4'd9,
    S_MEM_WRITE = 4'd10,
    S_MEM_WB    = 4'd11,
    S_LUI       = 4'd12,
    S_AUIPC     = 4'd13,
    S_ERROR     = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRC_A_PC     = 2'd0;
  localparam logic [1:0] SRC_A_PC_OLD = 2'd1;
  localparam logic [1:0] SRC_A_RS1    = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_MEM    = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  // States in which the controller waits on mem_ready.
  function automatic logic is_wait_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/rv32i_alu_decoder.sv
// Combinational ALU operation select from controller state and instruction fields.
module rv32i_alu_decoder
  import alu_types::*;
  import rv32i_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4
) (
  input  state_e                state,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  alu_op_e op;

  // funct7[5] selects SUB only for register-register ops; for shifts it picks SRA in both forms.
  always_comb begin
    op = ALU_ADD;
    case (state)
      S_EXECUTE_R, S_EXECUTE_I: begin
        case (funct3)
          3'b000:  op = (funct7_5 && (opcode == OP_R)) ? ALU_SUB : ALU_ADD;
          3'b001:  op = ALU_SLL;
          3'b010:  op = ALU_SLT;
          3'b011:  op = ALU_SLTU;
          3'b100:  op = ALU_XOR;
          3'b101:  op = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  op = ALU_OR;
          default: op = ALU_AND;
        endcase
      end
      S_BRANCH: begin
        case (funct3[2:1])
          2'b10:   op = ALU_SLT;
          2'b11:   op = ALU_SLTU;
          default: op = ALU_SUB;
        endcase
      end
      S_LUI:   op = ALU_PASS_B;
      default: op = ALU_ADD;
    endcase
  end

  assign alu_control = ALU_CTRL_W'(op);

endmodule

// File: rtl/rv32i_multicycle_controller.sv
// Main control FSM for the multicycle RV32I datapath.
// Optional performance counters are built when RV32I_CONTROLLER_PERF_EN is defined.
//
// state     | meaning
// FETCH     | read instruction at PC, PC <= PC + 4 on mem_ready
// DECODE    | ALUOut <= PC_old + imm(B), dispatch on opcode
// MEM_ADDR  | ALUOut <= rs1 + imm (S for store, I for load)
// EXECUTE_R | ALUOut <= rs1 op rs2
// EXECUTE_I | ALUOut <= rs1 op imm(I)
// JAL       | rd <= PC_old + 4, PC <= PC_old + imm(J)
// JALR      | rd <= PC_old + 4, PC <= (rs1 + imm(I)) & ~1
// BRANCH    | compare rs1/rs2, PC <= ALUOut when taken
// ALU_WB    | rd <= ALUOut
// MEM_READ  | read at ALUOut, wait for mem_ready
// MEM_WRITE | write at ALUOut, wait for mem_ready
// MEM_WB    | rd <= memory data
// LUI       | rd <= imm(U)
// AUIPC     | rd <= PC_old + imm(U)
// ERROR     | sticky trap, left only through rst
module rv32i_multicycle_controller
  import alu_types::*;
  import rv32i_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ALU_CTRL_W     = 4,
  parameter int CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [31:0]           instr,
  input  logic                  alu_zero,
  input  logic                  alu_lsb,
  input  logic                  mem_ready,
  output logic                  pc_ena,
  output logic                  ir_ena,
  output logic                  mem_src,
  output logic                  mem_wr_ena,
  output logic                  reg_write,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [2:0]            imm_type,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [3:0]            state,
  output logic                  error
`ifdef RV32I_CONTROLLER_PERF_EN
  ,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [CNT_W-1:0]      instret_count
`endif
);

  // The counter only has to reach TIMEOUT_CYCLES-1: the last not-ready cycle traps directly.
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  logic [TO_W-1:0]   wait_cnt;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              is_store;
  logic              timeout_hit;
  logic              branch_taken;
  logic              pc_raw, ir_raw, mw_raw, rw_raw;
  logic [ALU_CTRL_W-1:0] dec_alu;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign is_store    = (opcode == OP_STORE);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TO_LAST);

  logic unused_instr;
  assign unused_instr = &{1'b0, instr[31], instr[29:15], instr[11:7]};

  // Branch condition from the ALU flags; the ALU runs SUB, SLT or SLTU to match.
  always_comb begin
    case (funct3)
      3'b000:         branch_taken = alu_zero;
      3'b001:         branch_taken = ~alu_zero;
      3'b100, 3'b110: branch_taken = alu_lsb;
      3'b101, 3'b111: branch_taken = ~alu_lsb;
      default:        branch_taken = 1'b0;
    endcase
  end

  // Next-state selection; a not-ready wait traps once the limit is reached.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)        state_d = S_DECODE;
        else if (timeout_hit) state_d = S_ERROR;
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_R:              state_d = S_EXECUTE_R;
          OP_IMM:            state_d = S_EXECUTE_I;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_ERROR;
        endcase
      end
      S_MEM_ADDR: state_d = is_store ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (mem_ready)        state_d = S_MEM_WB;
        else if (timeout_hit) state_d = S_ERROR;
      end
      S_MEM_WRITE: begin
        if (mem_ready)        state_d = S_FETCH;
        else if (timeout_hit) state_d = S_ERROR;
      end
      S_EXECUTE_R, S_EXECUTE_I: state_d = S_ALU_WB;
      S_ALU_WB, S_MEM_WB, S_JAL, S_JALR, S_BRANCH, S_LUI, S_AUIPC: state_d = S_FETCH;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  // State and wait counter; everything holds while ena is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
    end else if (ena) begin
      state_q <= state_d;
      if ((state_d == state_q) && is_wait_state(state_q))
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
    end
  end

  // Datapath enables and selects decoded from the current state.
  always_comb begin
    pc_raw     = 1'b0;
    ir_raw     = 1'b0;
    mw_raw     = 1'b0;
    rw_raw     = 1'b0;
    mem_src    = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    result_src = RES_ALUOUT;
    imm_type   = IMM_I;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALU;
          pc_raw     = mem_ready;
          ir_raw     = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRC_A_PC_OLD;
          alu_src_b = SRC_B_IMM;
          imm_type  = IMM_B;
        end
        S_MEM_ADDR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          imm_type  = is_store ? IMM_S : IMM_I;
        end
        S_MEM_READ: mem_src = 1'b1;
        S_MEM_WRITE: begin
          mem_src = 1'b1;
          mw_raw  = 1'b1;
        end
        S_MEM_WB: begin
          rw_raw     = 1'b1;
          result_src = RES_MEM;
        end
        S_EXECUTE_R: alu_src_a = SRC_A_RS1;
        S_EXECUTE_I: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
        end
        S_ALU_WB: rw_raw = 1'b1;
        // The ALU forms the jump target; the link value PC_old + 4 reaches rd on its own path.
        S_JAL: begin
          alu_src_a  = SRC_A_PC_OLD;
          alu_src_b  = SRC_B_IMM;
          imm_type   = IMM_J;
          result_src = RES_ALU;
          pc_raw     = 1'b1;
          rw_raw     = 1'b1;
        end
        S_JALR: begin
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = SRC_B_IMM;
          result_src = RES_ALU;
          pc_raw     = 1'b1;
          rw_raw     = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = SRC_A_RS1;
          pc_raw    = branch_taken;
        end
        S_LUI: begin
          alu_src_b  = SRC_B_IMM;
          imm_type   = IMM_U;
          result_src = RES_ALU;
          rw_raw     = 1'b1;
        end
        S_AUIPC: begin
          alu_src_a  = SRC_A_PC_OLD;
          alu_src_b  = SRC_B_IMM;
          imm_type   = IMM_U;
          result_src = RES_ALU;
          rw_raw     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pc_ena     = pc_raw & ena;
  assign ir_ena     = ir_raw & ena;
  assign mem_wr_ena = mw_raw & ena;
  assign reg_write  = rw_raw & ena;
  assign state      = state_q;
  assign error      = (state_q == S_ERROR);

  rv32i_alu_decoder #(
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_alu_decoder (
    .state       (state_q),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7_5    (instr[30]),
    .alu_control (dec_alu)
  );

  assign alu_control = rst ? ALU_CTRL_W'(ALU_ADD) : dec_alu;

`ifdef RV32I_CONTROLLER_PERF_EN
  // Cycle and retired-instruction counters; retirement is any return to FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else if (ena) begin
      if (state_q != S_ERROR)
        cycle_count <= cycle_count + 1'b1;
      if ((state_q != S_FETCH) && (state_q != S_ERROR) && (state_d == S_FETCH))
        instret_count <= instret_count + 1'b1;
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = 1'(CNT_W);
`endif

endmodule

// File: doc/rv32i_multicycle_controller.md
Name: rv32i_multicycle_controller

Overview:
Parametrised main control FSM for the multicycle RV32I datapath; it drives every datapath enable and mux select, and decodes ALU operations.
Generalises the earlier inline control with:
- a memory ready/wait handshake with configurable timeout
- an ena freeze
- a sticky ERROR trap for illegal opcodes and memory timeouts
- optional performance counters
It sits between the instruction register/ALU flags and the datapath register and memory enables inside the core.

Parameters:
TIMEOUT_CYCLES, 16, consecutive not-ready wait cycles before a memory access traps to ERROR; 0 disables the timeout
ALU_CTRL_W, 4, width of alu_control; encoding from the shared alu_types package
CNT_W, 32, width of the performance counters (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ena  in  1  when 0, all state, counters and the timeout counter hold, and all write enables are forced to 0
instr  in  32  contents of the instruction register
alu_zero  in  1  ALU result == 0
alu_lsb  in  1  bit 0 of the ALU result; SLT/SLTU outcome in BRANCH
mem_ready  in  1  memory completes the current access this cycle
pc_ena  out  1  PC and PC_old registers load
ir_ena  out  1  instruction register load
mem_src  out  1  0 = PC, 1 = ALUOut
mem_wr_ena  out  1  memory write strobe
reg_write  out  1  register file write
alu_src_a  out  2  0 = PC, 1 = PC_old, 2 = rs1 data
alu_src_b  out  2  0 = rs2 data, 1 = imm_ext, 2 = constant 4
result_src  out  2  0 = ALUOut, 1 = mem data, 2 = ALU result
imm_type  out  3  0 = I, 1 = S, 2 = B, 3 = U, 4 = J
alu_control  out  ALU_CTRL_W  ALU operation
state  out  4  current state code (debug)
error  out  1  sticky trap flag

Behaviour:
- Reset:
  - state = FETCH, timeout counter = 0, error = 0.
  - All enables 0; all selects 0; alu_control = ADD.
- Outputs are a combinational (Moore) function of state, plus instr fields and mem_ready where noted below.
- State codes: FETCH 0, DECODE 1, MEM_ADDR 2, EXECUTE_R 3, EXECUTE_I 4, JAL 5, JALR 6, BRANCH 7, ALU_WB 8, MEM_READ 9, MEM_WRITE 10, MEM_WB 11, LUI 12, AUIPC 13, ERROR 15.
- FETCH:
  - mem_src = 0; PC + 4 is computed on the ALU.
  - ir_ena = pc_ena = mem_ready.
  - Moves to DECODE only on mem_ready = 1; otherwise stays and increments the timeout counter.
- DECODE:
  - ALU computes PC_old + imm(B) into ALUOut.
  - Next state by opcode: load/store → MEM_ADDR; R-type → EXECUTE_R; OP-IMM → EXECUTE_I; JAL → JAL; JALR → JALR; BRANCH → BRANCH; LUI → LUI; AUIPC → AUIPC.
  - Any other opcode → ERROR.
- MEM_ADDR: rs1 + imm, with imm type S for stores and I for loads. Next state MEM_WRITE for stores, MEM_READ for loads.
- MEM_READ and MEM_WRITE:
  - mem_src = 1; mem_wr_ena = 1 in MEM_WRITE only, for every waiting cycle.
  - Access completes on mem_ready. MEM_READ then goes to MEM_WB; MEM_WRITE goes to FETCH.
- MEM_WB: reg_write = 1, result_src = 1, then FETCH.
- EXECUTE_R / EXECUTE_I:
  - alu_control is decoded from funct3 and funct7[5]; funct7[5] applies to SUB (R-type only) and SRA/SRAI.
  - Next state ALU_WB (reg_write = 1, result_src = 0), then FETCH.
- JAL and JALR:
  - PC_old + 4 is written to rd.
  - pc_ena = 1 with result_src = 2. Target is PC_old + imm(J) for JAL, and (rs1 + imm(I)) with bit 0 cleared for JALR.
  - One cycle, then FETCH.
- BRANCH:
  - beq/bne use SUB and alu_zero; blt/bge use SLT and alu_lsb; bltu/bgeu use SLTU and alu_lsb.
  - If taken: pc_ena = 1, result_src = 0. Then FETCH.
- LUI: rd = imm(U) via ALU pass-B. AUIPC: rd = PC_old + imm(U). Each is one cycle, then FETCH.
- Timeout:
  - Counter is cleared on every state change.
  - Trap to ERROR when the counter reaches TIMEOUT_CYCLES while waiting; there is no trap when TIMEOUT_CYCLES = 0.
  - mem_ready in the same cycle as the count reaching the limit: the access completes and there is no trap.
- ERROR:
  - error = 1; all enables 0.
  - Left only by rst; ena is ignored for the exit.
- ena = 0: no state or counter update, and all write enables are 0. This applies mid-wait as well: the counter holds while ena = 0.
- rst in any state, including mid-wait or ERROR: FETCH on the next edge.

Optional Feature:
- RV32I_CONTROLLER_PERF_EN defined:
  - Adds outputs cycle_count and instret_count, each CNT_W wide.
  - cycle_count increments every ena = 1 cycle that is not in ERROR.
  - instret_count increments on each transition into FETCH from a non-FETCH state.
  - Both wrap modulo 2^CNT_W; both reset to 0.
- Undefined: the outputs do not exist and no counter logic is generated.

Decomposition:
- Shared package rv32i_ctrl_pkg holds:
  - the state enum
  - opcode constants
  - the alu_src_a, alu_src_b, result_src and imm_type encodings
- ALU control encodings stay in the shared alu_types package.
- One sub-module, rv32i_alu_decoder, is natural: a combinational map of state, opcode, funct3 and funct7[5] to alu_control.

Test Plan:
- addi x1,x0,5 with mem_ready tied high → state sequence FETCH, DECODE, EXECUTE_I, ALU_WB, FETCH. reg_write is high for 1 cycle. pc_ena pulses once.
- lw with mem_ready low for 3 cycles in MEM_READ → state held for 4 cycles, mem_src = 1 throughout, then MEM_WB with result_src = 1.
- TIMEOUT_CYCLES = 4, mem_ready stuck low in FETCH → error = 1 after 4 wait cycles. error remains set through 20 more cycles and clears only after rst.
- beq with alu_zero = 1, then bne with alu_zero = 1 → pc_ena = 1 in BRANCH for beq, pc_ena = 0 for bne.
- ena dropped for 5 cycles in MEM_WRITE with mem_ready low → mem_wr_ena = 0 and the counter frozen. On ena = 1 the access resumes and completes on mem_ready.
- Opcode 7'b0000000 → DECODE goes to ERROR. With PERF_EN defined, instret_count does not increment for this instruction.
